doorlock_entry_ctrl: RTL

//  Sequencer for the doorlock keypad path. Samples the 10-line one-hot keypad,

---
 rtl/doorlock_entry_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/doorlock_entry_ctrl.sv
// Doorlock keypad sequencer: digit capture, code compare, timed unlock and failure lockout.
// Define DOORLOCK_CODE_CHANGE_EN to add the prog input and the PROG (code change) state.
module doorlock_entry_ctrl #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                    UNLOCK_CYCLES  = 50000000,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCKOUT_CYCLES = 250000000,
    localparam int FAIL_W = ($clog2(MAX_FAIL + 1) < 2) ? 2 : $clog2(MAX_FAIL + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        key,
    input  logic              enter,
    input  logic              clear,
`ifdef DOORLOCK_CODE_CHANGE_EN
    input  logic              prog,
`endif
    output logic              unlocked,
    output logic              locked_out,
    output logic              digit_valid,
    output logic [3:0]        last_digit,
    output logic [3:0]        digit_cnt,
    output logic [FAIL_W-1:0] fail_cnt
);

    // state     | meaning
    // S_ENTRY   | collecting digits, waiting for enter
    // S_CHECK   | one-cycle compare of buffer against stored code
    // S_OPEN    | door unlocked for UNLOCK_CYCLES
    // S_LOCKOUT | all inputs ignored for LOCKOUT_CYCLES
    // S_PROG    | collecting a new code (DOORLOCK_CODE_CHANGE_EN only)
    localparam logic [2:0] S_ENTRY   = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_LOCKOUT = 3'd3;
`ifdef DOORLOCK_CODE_CHANGE_EN
    localparam logic [2:0] S_PROG    = 3'd4;
`endif

    localparam int CODE_W    = 4 * CODE_LEN;
    localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX);

    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]         CODE_LEN_C   = 4'(CODE_LEN);
    localparam logic [FAIL_W-1:0]  MAX_FAIL_C   = FAIL_W'(MAX_FAIL);

    logic [2:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [CODE_W-1:0]  buffer;
    logic [CODE_W-1:0]  code;

    logic [9:0] key_q, key_prev;
    logic       enter_q, enter_prev, clear_q, clear_prev;
    logic       press, enter_edge, clear_edge;
    logic [3:0] press_digit;
    logic       key_onehot, collecting, take_digit, match;
    logic [FAIL_W-1:0] fail_next;

    function automatic logic [3:0] encode(input logic [9:0] k);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++)
            if (k[i]) d = 4'(i);
        return d;
    endfunction

`ifdef DOORLOCK_CODE_CHANGE_EN
    logic prog_q, prog_prev, prog_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_q    <= 1'b0;
            prog_prev <= 1'b0;
            prog_edge <= 1'b0;
        end else begin
            prog_q    <= prog;
            prog_prev <= prog_q;
            prog_edge <= prog_q & ~prog_prev;
        end
    end
`else
    assign code = DEFAULT_CODE;
`endif

    // Events are registered one stage after the input flops so enter, clear and
    // key presses reach the FSM in the same cycle when their pins move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q       <= '0;
            key_prev    <= '0;
            enter_q     <= 1'b0;
            enter_prev  <= 1'b0;
            clear_q     <= 1'b0;
            clear_prev  <= 1'b0;
            press       <= 1'b0;
            press_digit <= '0;
            enter_edge  <= 1'b0;
            clear_edge  <= 1'b0;
        end else begin
            key_q       <= key;
            key_prev    <= key_q;
            press       <= key_onehot && (key_prev == '0);
            press_digit <= encode(key_q);
            enter_q     <= enter;
            enter_prev  <= enter_q;
            enter_edge  <= enter_q & ~enter_prev;
            clear_q     <= clear;
            clear_prev  <= clear_q;
            clear_edge  <= clear_q & ~clear_prev;
        end
    end

    assign key_onehot = (key_q != '0) && ((key_q & (key_q - 10'd1)) == '0);

`ifdef DOORLOCK_CODE_CHANGE_EN
    assign collecting = (state == S_ENTRY) || (state == S_PROG);
`else
    assign collecting = (state == S_ENTRY);
`endif

    assign take_digit = collecting && press && !enter_edge && !clear_edge && (digit_cnt < CODE_LEN_C);
    assign match      = (digit_cnt == CODE_LEN_C) && (buffer == code);
    assign fail_next  = (fail_cnt == MAX_FAIL_C) ? fail_cnt : fail_cnt + FAIL_W'(1);
    assign unlocked   = (state == S_OPEN);
    assign locked_out = (state == S_LOCKOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_ENTRY;
            timer       <= '0;
            buffer      <= '0;
            digit_cnt   <= '0;
            last_digit  <= '0;
            digit_valid <= 1'b0;
            fail_cnt    <= '0;
`ifdef DOORLOCK_CODE_CHANGE_EN
            code        <= DEFAULT_CODE;
`endif
        end else begin
            digit_valid <= 1'b0;
            case (state)
                S_ENTRY: begin
                    if (enter_edge) begin
                        state <= S_CHECK;
                    end else if (clear_edge) begin
                        buffer    <= '0;
                        digit_cnt <= '0;
                    end
                end
                S_CHECK: begin
                    buffer    <= '0;
                    digit_cnt <= '0;
                    if (match) begin
                        fail_cnt <= '0;
                        timer    <= UNLOCK_LOAD;
                        state    <= S_OPEN;
                    end else begin
                        fail_cnt <= fail_next;
                        if (fail_next == MAX_FAIL_C) begin
                            timer <= LOCKOUT_LOAD;
                            state <= S_LOCKOUT;
                        end else begin
                            state <= S_ENTRY;
                        end
                    end
                end
                S_OPEN: begin
                    if (timer == '0) state <= S_ENTRY;
                    else             timer <= timer - TIMER_W'(1);
`ifdef DOORLOCK_CODE_CHANGE_EN
                    if (prog_edge) begin
                        state     <= S_PROG;
                        buffer    <= '0;
                        digit_cnt <= '0;
                    end
`endif
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        fail_cnt <= '0;
                        state    <= S_ENTRY;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
`ifdef DOORLOCK_CODE_CHANGE_EN
                S_PROG: begin
                    if (enter_edge) begin
                        if (digit_cnt == CODE_LEN_C) code <= buffer;
                        buffer    <= '0;
                        digit_cnt <= '0;
                        state     <= S_ENTRY;
                    end else if (clear_edge) begin
                        buffer    <= '0;
                        digit_cnt <= '0;
                        state     <= S_ENTRY;
                    end
                end
`endif
                default: state <= S_ENTRY;
            endcase

            if (take_digit) begin
                buffer      <= (buffer << 4) | CODE_W'(press_digit);
                digit_cnt   <= digit_cnt + 4'd1;
                last_digit  <= press_digit;
                digit_valid <= 1'b1;
            end
        end
    end

endmodule
